// File: rtl/seven_segment_capture_if.sv
// seven_segment_capture_if: bundles the multiplexed display pins and the rebuilt digit outputs.
// Optional macro SEG_ERR_CNT_EN adds the err_count field (width ERR_CNT_W).
//
// Handshake semantics: there is no valid/ready pairing on this bus. An/Ca are free-running
// pin levels owned by the master (display driver side). The slave (capture) owns every other
// field. frame_done is a single-cycle strobe and needs no acknowledge. valid/err are level
// flags that describe the most recent capture of each digit.
interface seven_segment_capture_if
`ifdef SEG_ERR_CNT_EN
  #(parameter int ERR_CNT_W = 8)
`endif
  ;
  logic [3:0] An;
  logic [6:0] Ca;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] C;
  logic [3:0] D;
  logic [3:0] valid;
  logic [3:0] err;
  logic       frame_done;
`ifdef SEG_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_count;
`endif

  modport master (
    output An, Ca,
    input  A, B, C, D, valid, err, frame_done
`ifdef SEG_ERR_CNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  An, Ca,
    output A, B, C, D, valid, err, frame_done
`ifdef SEG_ERR_CNT_EN
    , output err_count
`endif
  );
endinterface

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: rebuilds four hex digits from time-multiplexed active-low
// anode/cathode lines. Pins pass through a 2-flop synchroniser. A dwell filter then
// requires STABLE_CYCLES identical samples before a single capture per dwell.
// Optional macro SEG_ERR_CNT_EN adds a saturating count of undecodable captures.
module seven_segment_capture #(
  parameter int STABLE_CYCLES = 16
`ifdef SEG_ERR_CNT_EN
  , parameter int ERR_CNT_W = 8
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  seven_segment_capture_if.slave bus
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Synchroniser, previous-sample and dwell state
  logic [3:0]       an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_prev_q, an_prev_d;
  logic [6:0]       ca_s1_q, ca_s1_d, ca_s2_q, ca_s2_d, ca_prev_q, ca_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Captured results
  logic [3:0][3:0]  digit_q, digit_d;
  logic [3:0]       valid_q, valid_d;
  logic [3:0]       err_q, err_d;
  logic [3:0]       seen_q, seen_d;
  logic             frame_done_q, frame_done_d;
`ifdef SEG_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

  // Intermediate decisions
  logic       same;
  logic       one_hot;
  logic [1:0] idx;
  logic       capture;
  logic       dec_ok;
  logic [3:0] dec_val;

  // Cathode pattern to hex digit; dec_ok low for anything outside the table (incl. blank)
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (ca_s2_q)
      7'h40: dec_val = 4'h0;
      7'h79: dec_val = 4'h1;
      7'h24: dec_val = 4'h2;
      7'h30: dec_val = 4'h3;
      7'h19: dec_val = 4'h4;
      7'h12: dec_val = 4'h5;
      7'h02: dec_val = 4'h6;
      7'h78: dec_val = 4'h7;
      7'h00: dec_val = 4'h8;
      7'h10: dec_val = 4'h9;
      7'h08: dec_val = 4'hA;
      7'h03: dec_val = 4'hB;
      7'h46: dec_val = 4'hC;
      7'h21: dec_val = 4'hD;
      7'h06: dec_val = 4'hE;
      7'h0E: dec_val = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // Anode select to digit index; only a single low bit is a real digit strobe
  always_comb begin
    one_hot = 1'b1;
    idx     = 2'd0;
    case (an_s2_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  // Dwell filter and capture bookkeeping
  always_comb begin
    an_s1_d      = bus.An;
    ca_s1_d      = bus.Ca;
    an_s2_d      = an_s1_q;
    ca_s2_d      = ca_s1_q;
    an_prev_d    = an_s2_q;
    ca_prev_d    = ca_s2_q;
    digit_d      = digit_q;
    valid_d      = valid_q;
    err_d        = err_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
`ifdef SEG_ERR_CNT_EN
    err_cnt_d    = err_cnt_q;
`endif

    same = ({an_s2_q, ca_s2_q} == {an_prev_q, ca_prev_q});

    // Any change or a non-digit anode state restarts the dwell
    if (!same || !one_hot)      cnt_d = '0;
    else if (cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;
    else                        cnt_d = cnt_q;

    // Fires on the single cycle the count reaches STABLE_CYCLES; saturation blocks repeats
    capture = same && one_hot && (cnt_q == CNT_LAST);

    if (capture) begin
      if (dec_ok) begin
        digit_d[idx] = dec_val;
        valid_d[idx] = 1'b1;
        err_d[idx]   = 1'b0;
      end else begin
        err_d[idx]   = 1'b1;
`ifdef SEG_ERR_CNT_EN
        if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
`endif
      end
      seen_d[idx] = 1'b1;
      if (seen_d == 4'hF) begin
        frame_done_d = 1'b1;
        seen_d       = 4'h0;
      end
    end
  end

  // State registers; synchroniser resets to the idle (all-off) pin value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_s1_q      <= 4'hF;
      ca_s1_q      <= 7'h7F;
      an_s2_q      <= 4'hF;
      ca_s2_q      <= 7'h7F;
      an_prev_q    <= 4'hF;
      ca_prev_q    <= 7'h7F;
      cnt_q        <= '0;
      digit_q      <= '0;
      valid_q      <= 4'h0;
      err_q        <= 4'h0;
      seen_q       <= 4'h0;
      frame_done_q <= 1'b0;
`ifdef SEG_ERR_CNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      an_s1_q      <= an_s1_d;
      ca_s1_q      <= ca_s1_d;
      an_s2_q      <= an_s2_d;
      ca_s2_q      <= ca_s2_d;
      an_prev_q    <= an_prev_d;
      ca_prev_q    <= ca_prev_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
`ifdef SEG_ERR_CNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign bus.A          = digit_q[0];
  assign bus.B          = digit_q[1];
  assign bus.C          = digit_q[2];
  assign bus.D          = digit_q[3];
  assign bus.valid      = valid_q;
  assign bus.err        = err_q;
  assign bus.frame_done = frame_done_q;
`ifdef SEG_ERR_CNT_EN
  assign bus.err_count  = err_cnt_q;
`endif
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: drives pin segments (directed then random) and predicts, per
// segment, whether and when a capture lands and the full output state after it.
module tb_seven_segment_capture;
  localparam int S = 16;
`ifdef SEG_ERR_CNT_EN
  localparam int ERR_CNT_W = 8;
  localparam int SW = 25 + ERR_CNT_W;
`else
  localparam int SW = 25;
`endif

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

`ifdef SEG_ERR_CNT_EN
  seven_segment_capture_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();
  seven_segment_capture #(.STABLE_CYCLES(S), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clock(clock), .reset(reset), .bus(bus));
`else
  seven_segment_capture_if bus ();
  seven_segment_capture #(.STABLE_CYCLES(S)) dut (
    .clock(clock), .reset(reset), .bus(bus));
`endif

  // Scoreboard
  logic [SW-1:0] exp_q[$];
  int unsigned   time_q[$];
  logic [SW-1:0] cur_exp;
  bit            in_reset;
  int            total = 0;
  int            bad   = 0;

  // Reference model state
  logic [6:0] seg_tab [16];
  logic [3:0] m_dig [4];
  logic [3:0] m_vld, m_err, m_seen;
  int         m_ecnt;
  logic [3:0] last_an;
  logic [6:0] last_ca;

  function automatic logic [SW-1:0] dut_snap();
    logic [SW-1:0] s;
`ifdef SEG_ERR_CNT_EN
    s = {bus.frame_done, bus.A, bus.B, bus.C, bus.D, bus.valid, bus.err, bus.err_count};
`else
    s = {bus.frame_done, bus.A, bus.B, bus.C, bus.D, bus.valid, bus.err};
`endif
    return s;
  endfunction

  function automatic logic [SW-1:0] model_snap(input logic fd);
    logic [SW-1:0] s;
`ifdef SEG_ERR_CNT_EN
    s = {fd, m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_vld, m_err, ERR_CNT_W'(m_ecnt)};
`else
    s = {fd, m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_vld, m_err};
`endif
    return s;
  endfunction

  task automatic check(input logic [SW-1:0] got, input logic [SW-1:0] want, input string name);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_vld = 4'h0; m_err = 4'h0; m_seen = 4'h0; m_ecnt = 0;
    last_an = 4'hF; last_ca = 7'h7F;
  endtask

  function automatic int digit_of(input logic [3:0] an);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) r = i;
    return r;
  endfunction

  // One capture of digit i with cathode pattern ca, pushed for checking at edge t
  task automatic model_capture(input int i, input logic [6:0] ca, input int unsigned t);
    int  v;
    logic fd;
    v = -1;
    for (int k = 0; k < 16; k++) if (seg_tab[k] == ca) v = k;
    if (v >= 0) begin
      m_dig[i] = 4'(v); m_vld[i] = 1'b1; m_err[i] = 1'b0;
    end else begin
      m_err[i] = 1'b1;
`ifdef SEG_ERR_CNT_EN
      if (m_ecnt < (1 << ERR_CNT_W) - 1) m_ecnt++;
`endif
    end
    m_seen[i] = 1'b1;
    fd = (m_seen == 4'hF);
    if (fd) m_seen = 4'h0;
    exp_q.push_back(model_snap(fd));
    time_q.push_back(t);
  endtask

  // Driver: hold {an,ca} for n cycles starting at the next rising edge (call at negedge)
  task automatic seg(input logic [3:0] an, input logic [6:0] ca, input int n);
    int i;
    int unsigned k;
    i = digit_of(an);
    if (an == last_an && ca == last_ca && i >= 0) begin
      bus.An = 4'hF; bus.Ca = 7'h7F;
      last_an = 4'hF; last_ca = 7'h7F;
      @(negedge clock);
    end
    k = cyc + 1;
    if (i >= 0 && n >= S + 1) model_capture(i, ca, k + 2 + S);
    bus.An = an; bus.Ca = ca;
    last_an = an; last_ca = ca;
    repeat (n) @(negedge clock);
  endtask

  // Monitor: compares at every negedge; a queued capture is due exactly at its edge
  initial begin
    forever begin
      @(negedge clock);
      if (!in_reset) begin
        if (time_q.size() > 0 && time_q[0] == cyc) begin
          void'(time_q.pop_front());
          cur_exp = exp_q.pop_front();
          check(dut_snap(), cur_exp, "capture");
          cur_exp[SW-1] = 1'b0;
        end else begin
          check(dut_snap(), cur_exp, "hold");
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [3:0] an;
    logic [6:0] ca;
    int         n;
    int         r;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    model_reset();
    cur_exp  = '0;
    in_reset = 1'b1;
    bus.An = 4'hF; bus.Ca = 7'h7F;
    repeat (3) @(negedge clock);
    check(dut_snap(), '0, "reset_state");
    reset    = 1'b0;
    in_reset = 1'b0;
    @(negedge clock);

    // Single digit A=3, no frame
    seg(4'b1110, 7'h30, 40);
    // Too short a dwell on B, then a non-capturing gap
    seg(4'b1101, 7'h79, 10);
    seg(4'b1011, 7'h7F, 5);
    // Two full scans, one frame pulse each
    for (int p = 0; p < 2; p++) begin
      seg(4'b1110, 7'h79, 32);
      seg(4'b1101, 7'h24, 32);
      seg(4'b1011, 7'h30, 32);
      seg(4'b0111, 7'h19, 32);
    end
    // Blank pattern is an error, then recovery with F
    seg(4'b1011, 7'h7F, 32);
    seg(4'b1011, 7'h0E, 32);
    seg(4'b1100, 7'h40, 32);
    seg(4'b0000, 7'h79, 32);
    seg(4'b1111, 7'h24, 32);
    // Boundary dwell lengths: one short of capture, exactly enough
    seg(4'b0111, 7'h12, S);
    seg(4'b0111, 7'h02, S + 1);

    // Randomised segments
    for (int s = 0; s < 220; s++) begin
      r = $urandom_range(0, 9);
      if (r <= 5 || r == 9) an = ~(4'b0001 << $urandom_range(0, 3));
      else if (r == 6)      an = 4'hF;
      else if (r == 7)      an = 4'h0;
      else                  an = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) ca = seg_tab[$urandom_range(0, 15)];
      else                           ca = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 0) n = $urandom_range(1, S);
      else                           n = $urandom_range(S + 1, S + 24);
      seg(an, ca, n);
    end

    // Drain outstanding captures, bounded
    n = 0;
    while (time_q.size() > 0 && n < 4 * S) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (time_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", time_q.size());
    end

    // Asynchronous reset mid-dwell with digits loaded
    seg(4'b1101, 7'h46, 6);
    #2;
    in_reset = 1'b1;
    reset    = 1'b1;
    #1;
    check(dut_snap(), '0, "async_reset");
    exp_q.delete();
    time_q.delete();
    model_reset();
    cur_exp = '0;
    bus.An = 4'hF; bus.Ca = 7'h7F;
    repeat (3) @(negedge clock);
    check(dut_snap(), '0, "reset_hold");
    reset    = 1'b0;
    in_reset = 1'b0;
    @(negedge clock);

    // Post-reset capture
    seg(4'b0111, 7'h21, 30);
    seg(4'b1110, 7'h08, 25);
    repeat (4) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
